// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: valid/ready handshake carrying {pc, inst} from fetch to decode
interface if_fetch_queue_if #(parameter int ADDR_W = 32, parameter int INST_W = 32);
  logic              valid;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst;
  logic              ready;
  modport master (output valid, pc, inst, input ready);
  modport slave  (input valid, pc, inst, output ready);
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner and ROM driver feeding a FWFT {pc, inst} queue toward decode
module if_fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          new_pc,
  input  logic                       branch_flag,
  input  logic [ADDR_W-1:0]          branch_target,
  output logic                       rom_ce,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [INST_W-1:0]          rom_inst,
  if_fetch_queue_if.master           id,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] pc;
  logic              ce_q;
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     count;
  logic              pop, redir, fetch;
  logic [ADDR_W-1:0] tgt;
  assign pop      = id.valid & id.ready;
  assign redir    = flush | branch_flag;
  assign fetch    = ce_q & ~redir & ((count < CW'(DEPTH)) | pop);
  assign tgt      = flush ? new_pc : branch_target;
  assign rom_ce   = fetch;
  assign rom_addr = pc;
  assign q_count  = count;
  assign id.valid = count != '0;
  assign id.pc    = id.valid ? mem_pc[rp] : '0;
  assign id.inst  = id.valid ? mem_inst[rp] : '0;
  // PC, enable and queue bookkeeping; a redirect empties the queue and retargets the PC
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc    <= RESET_PC;
      ce_q  <= 1'b0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      ce_q <= 1'b1;
      if (redir) begin
        pc    <= {tgt[ADDR_W-1:2], 2'b00};
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (fetch) begin
          pc <= pc + ADDR_W'(4);
          wp <= wp + PW'(1);
        end
        if (pop) rp <= rp + PW'(1);
        count <= count + CW'(fetch) - CW'(pop);
      end
    end
  // Queue storage; contents beyond the occupancy are never presented, so no reset is needed
  always_ff @(posedge clk)
    if (fetch) begin
      mem_pc[wp]   <= pc;
      mem_inst[wp] <= rom_inst;
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: queue-model checked random and directed fetch/redirect/reset scenarios
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, branch_flag = 1'b0;
  logic [31:0] new_pc = '0, branch_target = '0;
  logic        rom_ce, rom_ce2;
  logic [31:0] rom_addr, rom_addr2, rom_inst, rom_inst2;
  logic [2:0]  q_count, q_count2;
  int          total = 0, bad = 0;
  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic        mce;

  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(32), .INST_W(32)) id ();
  if_fetch_queue_if #(.ADDR_W(32), .INST_W(32)) id2 ();

  assign rom_inst  = 32'h1000 + (rom_addr >> 2);
  assign rom_inst2 = 32'h1000 + (rom_addr2 >> 2);

  if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag),
    .branch_target(branch_target), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id(id), .q_count(q_count));

  if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0), .new_pc(32'h0), .branch_flag(1'b0),
    .branch_target(32'h0), .rom_ce(rom_ce2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
    .id(id2), .q_count(q_count2));

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic mreset();
    mq.delete();
    mpc = 32'h0;
    mce = 1'b0;
  endtask

  // Called just after a falling edge with inputs set: compare against the model, then advance it
  task automatic cyc();
    logic redir, pop, fetch;
    #2;
    redir = flush | branch_flag;
    pop   = mq.size() > 0 && id.ready;
    fetch = mce && !redir && (mq.size() < 4 || pop);
    chk("valid", id.valid, mq.size() > 0);
    chk("head_pc", id.pc, mq.size() > 0 ? mq[0][63:32] : 32'h0);
    chk("head_inst", id.inst, mq.size() > 0 ? mq[0][31:0] : 32'h0);
    chk("count", q_count, mq.size());
    chk("rom_ce", rom_ce, fetch);
    chk("rom_addr", rom_addr, mpc);
    @(posedge clk);
    if (!rst) mreset();
    else begin
      if (redir) begin
        mq.delete();
        mpc = (flush ? new_pc : branch_target) & ~32'h3;
      end else begin
        if (pop) void'(mq.pop_front());
        if (fetch) begin
          mq.push_back({mpc, rom(mpc)});
          mpc = mpc + 32'h4;
        end
      end
      mce = 1'b1;
    end
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the immediate clear, releases on a later falling edge
  task automatic areset();
    #1 rst = 1'b0;
    mreset();
    #1;
    chk("arst_valid", id.valid, 0);
    chk("arst_count", q_count, 0);
    chk("arst_rom_ce", rom_ce, 0);
    chk("arst_valid2", id2.valid, 0);
    @(negedge clk);
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    id.ready  = 1'b1;
    id2.ready = 1'b1;
    mreset();
    rst = 1'b0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_rom_ce", rom_ce, 0);
    chk("rst_pc", id.pc, 0);
    rst = 1'b1;
    cyc();
    chk("t1_first_valid", id.valid, 0);
    cyc();
    chk("t1_pc0", id.pc, 32'h0);
    chk("t1_inst0", id.inst, 32'h1000);
    chk("t5_pc0", id2.pc, 32'hFFFF_FFFC);
    chk("t5_valid", id2.valid, 1);
    cyc();
    chk("t1_pc1", id.pc, 32'h4);
    chk("t5_pc1", id2.pc, 32'h0);
    chk("t5_inst1", id2.inst, 32'h1000);
    cyc();
    chk("t1_pc2", id.pc, 32'h8);

    id.ready = 1'b0;
    areset();
    repeat (7) cyc();
    chk("t2_count", q_count, 4);
    chk("t2_rom_ce", rom_ce, 0);
    chk("t2_hold_pc", rom_addr, 32'h10);
    id.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_drain_valid", id.valid, 1);
      chk("t2_drain_pc", id.pc, 32'(4 * i));
      cyc();
    end

    id.ready = 1'b0;
    repeat (6) cyc();
    chk("t6_full", q_count, 4);
    areset();
    id.ready = 1'b1;
    cyc();
    cyc();
    chk("t6_restart_pc", id.pc, 32'h0);

    id.ready = 1'b0;
    areset();
    repeat (3) cyc();
    chk("t3_count2", q_count, 2);
    branch_flag   = 1'b1;
    branch_target = 32'h200;
    cyc();
    branch_flag = 1'b0;
    chk("t3_count0", q_count, 0);
    chk("t3_valid0", id.valid, 0);
    cyc();
    chk("t3_pc", id.pc, 32'h200);
    chk("t3_inst", id.inst, 32'h1080);

    flush  = 1'b1;
    new_pc = 32'h380;
    branch_flag = 1'b1;
    cyc();
    flush = 1'b0;
    branch_flag = 1'b0;
    cyc();
    chk("t4_flush_wins", id.pc, 32'h380);
    branch_flag   = 1'b1;
    branch_target = 32'h203;
    cyc();
    branch_flag = 1'b0;
    cyc();
    chk("t4_align", id.pc, 32'h200);

    repeat (500) begin
      id.ready      = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 19) == 0);
      branch_flag   = ($urandom_range(0, 9) == 0);
      new_pc        = $urandom;
      branch_target = $urandom;
      if ($urandom_range(0, 99) == 0) areset();
      else cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
